// File: rtl/reset_seq_pkg.sv
// Shared types and defaults for the staged reset sequencer.
package reset_seq_pkg;

  localparam int unsigned STAGE_W = 3;

  // 100 us guard gap and 500 ms ready watchdog at 10 MHz
  localparam int unsigned DEF_GAP_CYCLES     = 1000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 5000000;

  typedef logic [1:0] state_t;
  localparam state_t ST_HOLD = 2'd0;
  localparam state_t ST_GAP  = 2'd1;
  localparam state_t ST_WAIT = 2'd2;
  localparam state_t ST_RUN  = 2'd3;

  function automatic logic [STAGE_W-1:0] lowest_set(input logic [7:0] v);
    logic [STAGE_W-1:0] idx;
    idx = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) idx = STAGE_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous level, clears to 0 on reset.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset controller: releases stages in order behind ready handshakes and guard gaps.
// Define RESET_SEQ_WATCHDOG_EN to build the ready-wait watchdog and sticky fault report.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned NUM_STAGES       = 4,
  parameter int unsigned GAP_CYCLES       = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter int unsigned SW_RESTART_STAGE = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_STAGES-1:0] stage_ready,
  input  logic                  sw_reset_req,
  output logic [NUM_STAGES-1:0] stage_rst_n,
  output logic                  seq_done,
  output logic [STAGE_W-1:0]    stage_idx,
  output logic                  fault,
  output logic [STAGE_W-1:0]    fault_stage
);

  localparam int unsigned        GapW    = $clog2(GAP_CYCLES) + 1;
  localparam logic [GapW-1:0]    GapLast = GapW'(GAP_CYCLES);
  localparam logic [STAGE_W-1:0] LastIdx = STAGE_W'(NUM_STAGES - 1);
  localparam logic [STAGE_W-1:0] SwIdx   = STAGE_W'(SW_RESTART_STAGE);

  state_t                  state_q, state_d;
  logic [STAGE_W-1:0]      idx_q, idx_d;
  logic [GapW-1:0]         gap_q, gap_d;
  logic [NUM_STAGES-1:0]   rst_q, rst_d;
  logic                    done_q, done_d;
  logic [NUM_STAGES-1:0]   rdy_s, lost;
  logic [7:0]              lost_ext;
  logic                    rdy_cur, k_vld, s_vld, restart;
  logic [STAGE_W-1:0]      k_idx, r_idx;

  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .rst_n (reset),
      .d     (stage_ready[i]),
      .q     (rdy_s[i])
    );
  end

  always_comb begin
    rdy_cur = 1'b0;
    lost    = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      if (STAGE_W'(i) == idx_q) rdy_cur = rdy_s[i];
      // A drop only counts once the sequence has moved past that stage
      if ((state_q == ST_RUN || STAGE_W'(i) < idx_q) && !rdy_s[i]) lost[i] = 1'b1;
    end
    lost_ext                 = '0;
    lost_ext[NUM_STAGES-1:0] = lost;
    k_vld = |lost;
    k_idx = lowest_set(lost_ext);
    s_vld = sw_reset_req && (state_q != ST_HOLD) && !(state_q == ST_GAP && SwIdx > idx_q);
    r_idx = (k_vld && !(s_vld && SwIdx < k_idx)) ? k_idx : SwIdx;
    restart = k_vld || s_vld;
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  localparam int unsigned     WdogW    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [WdogW-1:0] WdogLast = WdogW'(TIMEOUT_CYCLES - 1);

  logic [WdogW-1:0]   wdog_q, wdog_d;
  logic               fault_q, fault_d;
  logic [STAGE_W-1:0] fstage_q, fstage_d;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    rst_d   = rst_q;
    done_d  = done_q;
`ifdef RESET_SEQ_WATCHDOG_EN
    wdog_d   = '0;
    fault_d  = fault_q;
    fstage_d = fstage_q;
`endif
    if (restart) begin
      for (int i = 0; i < NUM_STAGES; i++) begin
        if (STAGE_W'(i) >= r_idx) rst_d[i] = 1'b0;
      end
      idx_d   = r_idx;
      done_d  = 1'b0;
      gap_d   = '0;
      state_d = ST_GAP;
    end else begin
      unique case (state_q)
        ST_HOLD: begin
          idx_d   = '0;
          gap_d   = '0;
          state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == GapLast) begin
            for (int i = 0; i < NUM_STAGES; i++) begin
              if (STAGE_W'(i) == idx_q) rst_d[i] = 1'b1;
            end
            state_d = ST_WAIT;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (rdy_cur) begin
            if (idx_q == LastIdx) begin
              done_d  = 1'b1;
              state_d = ST_RUN;
            end else begin
              idx_d   = idx_q + 1'b1;
              gap_d   = '0;
              state_d = ST_GAP;
            end
          end
`ifdef RESET_SEQ_WATCHDOG_EN
          else if (wdog_q == WdogLast) begin
            fault_d  = 1'b1;
            fstage_d = idx_q;
            rst_d    = '0;
            idx_d    = '0;
            gap_d    = '0;
            state_d  = ST_GAP;
          end else begin
            wdog_d = wdog_q + 1'b1;
          end
`endif
        end
        ST_RUN: ;
        default: state_d = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HOLD;
      idx_q   <= '0;
      gap_q   <= '0;
      rst_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
    end
  end

`ifdef RESET_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wdog_q   <= '0;
      fault_q  <= 1'b0;
      fstage_q <= '0;
    end else begin
      wdog_q   <= wdog_d;
      fault_q  <= fault_d;
      fstage_q <= fstage_d;
    end
  end

  assign fault       = fault_q;
  assign fault_stage = fstage_q;
`else
  assign fault       = 1'b0;
  assign fault_stage = '0;
`endif

  assign stage_rst_n = rst_q;
  assign seq_done    = done_q;
  assign stage_idx   = idx_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized scoreboard bench for reset_sequencer; expected output changes come from an
// event-time model of the release sequence (edge numbers counted from reset release).
module tb_reset_sequencer;

  localparam int N   = 4;
  localparam int GAP = 4;
  localparam int TO  = 20;
  localparam int INF = 1 << 30;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] stage_ready;
  logic         sw_reset_req;
  logic [N-1:0] stage_rst_n;
  logic         seq_done;
  logic [2:0]   stage_idx;
  logic         fault;
  logic [2:0]   fault_stage;

  reset_sequencer #(
    .NUM_STAGES       (N),
    .GAP_CYCLES       (GAP),
    .TIMEOUT_CYCLES   (TO),
    .SW_RESTART_STAGE (1)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stage_ready  (stage_ready),
    .sw_reset_req (sw_reset_req),
    .stage_rst_n  (stage_rst_n),
    .seq_done     (seq_done),
    .stage_idx    (stage_idx),
    .fault        (fault),
    .fault_stage  (fault_stage)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         at;
    logic [3:0] rst;
    logic       done;
    logic [2:0] idx;
    logic       flt;
    logic [2:0] fst;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = -1;
  int         vis[N];      // first edge at which the DUT may act on stage j being ready
  int         rel_t[N];
  int         adv_t[N];
  logic       exp_flt = 1'b0;
  logic [2:0] exp_fst = 3'd0;
  logic [11:0] last_obs = '0;

  // Edge number: 0 is the first rising edge with reset high
  always @(posedge clk or negedge reset) begin
    if (!reset) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  always @(negedge clk) begin
    if ({stage_rst_n, seq_done, stage_idx, fault, fault_stage} !== last_obs) begin
      last_obs = {stage_rst_n, seq_done, stage_idx, fault, fault_stage};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_change cyc=%0d got rst_n=%b done=%b idx=%0d fault=%b fstage=%0d, required no change",
                 cyc, stage_rst_n, seq_done, stage_idx, fault, fault_stage);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.at != cyc || mon_e.rst !== stage_rst_n || mon_e.done !== seq_done ||
            mon_e.idx !== stage_idx || mon_e.flt !== fault || mon_e.fst !== fault_stage) begin
          n_bad++;
          $display("FAIL seq_event got cyc=%0d rst_n=%b done=%b idx=%0d fault=%b fstage=%0d, required cyc=%0d rst_n=%b done=%b idx=%0d fault=%b fstage=%0d",
                   cyc, stage_rst_n, seq_done, stage_idx, fault, fault_stage,
                   mon_e.at, mon_e.rst, mon_e.done, mon_e.idx, mon_e.flt, mon_e.fst);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout cyc=%0d required finish", cyc);
    $fatal(1, "bench time limit");
  end

  task automatic push(input int at, input logic [3:0] rst, input logic done, input logic [2:0] idx);
    ev_t e;
    e.at   = at;
    e.rst  = rst;
    e.done = done;
    e.idx  = idx;
    e.flt  = exp_flt;
    e.fst  = exp_fst;
    exp_q.push_back(e);
  endtask

  // Sequence entering the gap of stage r at edge t with stages below r released
  task automatic model_seq(input int t, input int r, input logic [3:0] base, output int done_at);
    int cur, rel, adv;
    logic [3:0] rv;
    cur     = t;
    rv      = base;
    done_at = INF;
    for (int j = r; j < N; j++) begin
      rel      = cur + GAP + 1;
      rv       = rv | (4'b0001 << j);
      rel_t[j] = rel;
      push(rel, rv, 1'b0, 3'(j));
      if (vis[j] >= INF) return;
      adv      = (rel + 1 > vis[j]) ? rel + 1 : vis[j];
      adv_t[j] = adv;
      if (j < N - 1) push(adv, rv, 1'b0, 3'(j + 1));
      else begin
        push(adv, rv, 1'b1, 3'(j));
        done_at = adv;
      end
      cur = adv;
    end
  endtask

  // Returns #2 after rising edge p
  task automatic wait_cyc(input int p);
    int guard;
    guard = 0;
    while (cyc < p && guard < 5000) begin
      @(posedge clk);
      #2;
      guard++;
    end
    if (cyc != p) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_bound got cyc=%0d required %0d", cyc, p);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d required=%0d", name, got, want);
    end
  endtask

  task automatic start_seq();
    int da;
    for (int j = 0; j < N; j++) vis[j] = 2;
    exp_flt = 1'b0;
    exp_fst = 3'd0;
    model_seq(0, 0, 4'b0000, da);
    reset        = 1'b1;
    sw_reset_req = 1'b1;     // seen in ST_HOLD: no effect
    wait_cyc(0);
    sw_reset_req = 1'b0;
    wait_cyc(2);
    sw_reset_req = 1'b1;     // gap of stage 0, above idx: no effect
    wait_cyc(3);
    sw_reset_req = 1'b0;
    wait_cyc(da + 2);
  endtask

  task automatic do_sw();
    int p, da;
    p = cyc;
    push(p + 1, 4'b0001, 1'b0, 3'd1);
    model_seq(p + 1, 1, 4'b0001, da);
    sw_reset_req = 1'b1;
    wait_cyc(p + 1);
    sw_reset_req = 1'b0;
    wait_cyc(da + 2 + int'($urandom_range(0, 4)));
  endtask

  task automatic do_drop(input int i, input int d);
    int p, da;
    logic [3:0] base;
    p      = cyc;
    base   = 4'((1 << i) - 1);
    vis[i] = p + d + 3;
    push(p + 3, base, 1'b0, 3'(i));
    model_seq(p + 3, i, base, da);
    stage_ready[i] = 1'b0;
    wait_cyc(p + d);
    stage_ready[i] = 1'b1;
    wait_cyc(da + 2 + int'($urandom_range(0, 4)));
  endtask

  // Software request lands on the same edge the stage-0 drop is acted on
  task automatic do_simul(input int d);
    int p, da;
    p      = cyc;
    vis[0] = p + d + 3;
    push(p + 3, 4'b0000, 1'b0, 3'd0);
    model_seq(p + 3, 0, 4'b0000, da);
    stage_ready[0] = 1'b0;
    wait_cyc(p + 2);
    sw_reset_req = 1'b1;
    wait_cyc(p + 3);
    sw_reset_req = 1'b0;
    wait_cyc(p + d);
    stage_ready[0] = 1'b1;
    wait_cyc(da + 2);
  endtask

  task automatic do_stuck();
    int p, da, rel;
    p      = cyc;
    vis[1] = INF;
    push(p + 3, 4'b0001, 1'b0, 3'd1);
    model_seq(p + 3, 1, 4'b0001, da);
    rel = rel_t[1];
    stage_ready[1] = 1'b0;
`ifdef RESET_SEQ_WATCHDOG_EN
    exp_flt = 1'b1;
    exp_fst = 3'd1;
    push(rel + TO, 4'b0000, 1'b0, 3'd0);
    vis[1] = rel + TO + 3;
    model_seq(rel + TO, 0, 4'b0000, da);
    wait_cyc(rel + TO);
    stage_ready[1] = 1'b1;
    wait_cyc(da + 2);
`else
    wait_cyc(rel + 40);
    chk("hang_rst_n", int'(stage_rst_n), 3);
    chk("hang_idx", int'(stage_idx), 1);
    chk("hang_done", int'(seq_done), 0);
    chk("hang_fault", int'(fault), 0);
    p      = cyc;
    vis[1] = p + 3;
    push(p + 3, 4'b0011, 1'b0, 3'd2);
    model_seq(p + 3, 2, 4'b0011, da);
    stage_ready[1] = 1'b1;
    wait_cyc(da + 2);
`endif
  endtask

  task automatic do_midreset();
    int p, da;
    p = cyc;
    push(p + 1, 4'b0001, 1'b0, 3'd1);
    model_seq(p + 1, 1, 4'b0001, da);
    sw_reset_req = 1'b1;
    wait_cyc(p + 1);
    sw_reset_req = 1'b0;
    wait_cyc(adv_t[1] + int'($urandom_range(1, GAP)));
    exp_q.delete();
    reset   = 1'b0;
    exp_flt = 1'b0;
    exp_fst = 3'd0;
    push(-1, 4'b0000, 1'b0, 3'd0);
    #1;
    chk("midrst_rst_n", int'(stage_rst_n), 0);
    chk("midrst_done", int'(seq_done), 0);
    chk("midrst_fault", int'(fault), 0);
    chk("midrst_idx", int'(stage_idx), 0);
    repeat (3) @(posedge clk);
    #2;
  endtask

  initial begin
    reset        = 1'b1;
    stage_ready  = '1;
    sw_reset_req = 1'b0;
    #3 reset = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_stage_rst_n", int'(stage_rst_n), 0);
    chk("rst_seq_done", int'(seq_done), 0);
    chk("rst_stage_idx", int'(stage_idx), 0);
    chk("rst_fault", int'(fault), 0);
    chk("rst_fault_stage", int'(fault_stage), 0);

    start_seq();
    do_sw();
    do_drop(2, 4);
    do_simul(3 + int'($urandom_range(0, 5)));
    for (int it = 0; it < 10; it++) begin
      if ($urandom_range(0, 1) == 1) do_sw();
      else do_drop(int'($urandom_range(0, 3)), int'($urandom_range(1, 10)));
    end
    do_stuck();
    do_midreset();
    start_seq();

    repeat (4) @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reset_sequencer.md
# reset_sequencer

Staged reset controller between the board-level reset generator and the machine's functional blocks (clock/PLL domain, SDRAM controller, VIC/SID/CIA peripherals, 6510 core). It holds every stage in reset while the global reset is low. After release, it frees the stages one at a time in index order, waiting for each stage's ready handshake plus a guard gap before freeing the next. It also restarts the tail of the sequence on a software reset request or when a released stage loses its ready.

## Interface
Parameters:
- NUM_STAGES, 4: number of reset stages (2..8); stage 0 is freed first.
- GAP_CYCLES, 1000: guard cycles before each release (100 µs at 10 MHz); must be ≥1.
- TIMEOUT_CYCLES, 5000000: watchdog limit on the ready wait (500 ms at 10 MHz).
- SW_RESTART_STAGE, 1: first stage re-reset by a software request; must be < NUM_STAGES.

Ports:
- clk  in  1  10 MHz system clock; the only clock.
- reset  in  1  asynchronous, active-low; output of the board reset generator.
- stage_ready  in  NUM_STAGES  per-stage ready/ack; asynchronous to clk.
- sw_reset_req  in  1  single-cycle software restart request, synchronous to clk.
- stage_rst_n  out  NUM_STAGES  per-stage reset, active-low, registered.
- seq_done  out  1  high while all stages are released and ready.
- stage_idx  out  3  stage currently being sequenced.
- fault  out  1  sticky watchdog fault.
- fault_stage  out  3  stage that timed out.

## Operation
- States: ST_HOLD, ST_GAP, ST_WAIT, ST_RUN.
- Reset values (asynchronous on reset low): state ST_HOLD, stage_rst_n all 0, idx 0, counters 0, seq_done 0, fault 0, fault_stage 0.
- **ST_HOLD**: one cycle, then go to ST_GAP with idx=0.
- **ST_GAP**:
  - Count GAP_CYCLES.
  - On the final count, set stage_rst_n[idx]=1 and go to ST_WAIT.
  - The wait counter is cleared on entry to ST_WAIT.
- **ST_WAIT**: when rdy_s[idx] (synchronized ready) is high:
  - If idx==NUM_STAGES-1, go to ST_RUN.
  - Otherwise increment idx and go to ST_GAP.
- **ST_RUN**: seq_done=1; stage_idx holds NUM_STAGES-1.
- **Restart rule** (evaluated in ST_GAP, ST_WAIT and ST_RUN):
  - k = lowest released stage whose rdy_s has dropped; s = SW_RESTART_STAGE if sw_reset_req is high.
  - r = min(k, s) over whichever events are present.
  - Action: stage_rst_n[NUM_STAGES-1:r]=0, idx=r, seq_done=0, go to ST_GAP with the gap counter cleared.
  - Restart has priority over a normal transition in the same cycle.
  - sw_reset_req is ignored in ST_HOLD, and when r > idx while still in ST_GAP (those stages are already in reset).
- Stages below r keep their reset released.
- A stage's ready is only monitored once that stage is released.
- Counter widths: $clog2 of the respective parameter + 1; no wrap is permitted.

## Timing
- Ready synchronization adds 2 cycles (2-FF) before rdy_s changes.
- Fault-free start, with the first rising clk edge where reset reads high as cycle 0:
  - stage_rst_n[0] rises at cycle 1+GAP_CYCLES.
  - Stage n+1 releases GAP_CYCLES+1 cycles after rdy_s[n] is first seen high.
- seq_done rises 1 cycle after rdy_s[NUM_STAGES-1] is seen high.
- Restart response is 1 cycle after sw_reset_req, or 3 cycles after the raw stage_ready drop.
- Reset asserted mid-sequence: all outputs return to their reset values immediately (asynchronous); fault is cleared.

## Configuration
- Macro: RESET_SEQ_WATCHDOG_EN.
- Defined:
  - If ST_WAIT lasts TIMEOUT_CYCLES without rdy_s[idx], set fault=1 and fault_stage=idx.
  - Then restart from stage 0: all stages re-reset, go to ST_GAP with idx=0.
  - fault stays high until reset.
- Undefined:
  - ST_WAIT waits indefinitely; no timeout counter is built.
  - fault and fault_stage are tied 0.

## Structure
- Package reset_seq_pkg:
  - state enum (ST_HOLD/ST_GAP/ST_WAIT/ST_RUN);
  - default localparams: 10 MHz gap and timeout constants;
  - STAGE_W = 3.
- Sub-module sync_2ff: one instance per stage_ready bit, with reset to 0.

## Test plan
Bench parameters: NUM_STAGES=4, GAP_CYCLES=4, TIMEOUT_CYCLES=20, all readies tied high.
- **Normal start**: release reset → stage_rst_n steps 0001, 0011, 0111, 1111 at the cycle spacing given in Timing; seq_done=1 after stage 3.
- **Software restart**: in ST_RUN, pulse sw_reset_req → next cycle stage_rst_n=0001 and seq_done=0; stages 1..3 re-release in order.
- **Lost ready**: in ST_RUN, drop stage_ready[2] → 3 cycles later stage_rst_n=0011 and idx=2; restore ready → sequence completes.
- **Simultaneous events**: sw_reset_req in the same cycle that rdy_s[0] drops → stage_rst_n=0000, restart from idx 0.
- **Watchdog** (RESET_SEQ_WATCHDOG_EN defined): hold stage_ready[1] low → after 20 wait cycles fault=1, fault_stage=1, restart from stage 0. Without the macro, the sequence hangs with stage_rst_n=0011 and fault=0.
- **Mid-sequence reset**: pull reset low during ST_GAP of stage 2 → outputs immediately stage_rst_n=0000, seq_done=0, fault=0.
